// File: rtl/pb_event_capture.sv
// Push-button capture for a PIO input word: four debounced levels, sticky
// press flags and a 24-bit press counter packed as {counter, flags, levels}.
module pb_event_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_n_i,
    input  logic [3:0]  flag_clr_i,
    input  logic        cnt_clr_i,
    output logic [31:0] push_button_o
);

    localparam logic [19:0] LastCount = 20'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  sample;
    logic [3:0]  stable_q, stable_d;
    logic [19:0] db_cnt_q [4];
    logic [19:0] db_cnt_d [4];
    logic [3:0]  press;
    logic [3:0]  flag_q, flag_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] press_sum;

    // Two-flop synchronizer; resets to the released (high) pin level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign sample = ~sync2_q;

    // Per-button debounce: a differing sample must persist DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        press    = 4'b0;
        for (int n = 0; n < 4; n++) begin
            db_cnt_d[n] = 20'd0;
            if (sample[n] != stable_q[n]) begin
                if (db_cnt_q[n] == LastCount) begin
                    stable_d[n] = sample[n];
                    press[n]    = sample[n];
                end else begin
                    db_cnt_d[n] = db_cnt_q[n] + 20'd1;
                end
            end
        end
    end

    // Flags (set beats clear) and press counter (clear still counts this cycle's presses).
    always_comb begin
        press_sum = 24'(press[0]) + 24'(press[1]) + 24'(press[2]) + 24'(press[3]);
        flag_d    = (flag_q & ~flag_clr_i) | press;
        cnt_d     = cnt_clr_i ? press_sum : cnt_q + press_sum;
    end

    // All visible state advances on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 4'b0;
            flag_q   <= 4'b0;
            cnt_q    <= 24'd0;
            for (int n = 0; n < 4; n++) db_cnt_q[n] <= 20'd0;
        end else begin
            stable_q <= stable_d;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
            for (int n = 0; n < 4; n++) db_cnt_q[n] <= db_cnt_d[n];
        end
    end

    assign push_button_o = {cnt_q, flag_q, stable_q};

endmodule

// File: tb/tb_pb_event_capture.sv
// Self-checking bench for pb_event_capture with DEBOUNCE_CYCLES = 4.
module tb_pb_event_capture;

    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_n;
    logic [3:0]  flag_clr;
    logic        cnt_clr;
    logic [31:0] pb;

    typedef struct {
        logic [3:0]  key_n;
        logic [3:0]  fclr;
        logic        cclr;
        int          cycles;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    pb_event_capture #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n_i      (key_n),
        .flag_clr_i   (flag_clr),
        .cnt_clr_i    (cnt_clr),
        .push_button_o(pb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name);
        logic [31:0] exp;
        exp = sb.pop_front();
        n_checks++;
        if (pb !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, pb, exp);
        end
    endtask

    task automatic expect_now(input logic [31:0] exp, input string name);
        sb.push_back(exp);
        check(name);
    endtask

    // Inputs change at a negedge; strobes last one edge; output sampled at a negedge.
    task automatic apply(input vec_t v);
        key_n    = v.key_n;
        flag_clr = v.fclr;
        cnt_clr  = v.cclr;
        sb.push_back(v.exp);
        @(negedge clk);
        flag_clr = 4'h0;
        cnt_clr  = 1'b0;
        if (v.cycles > 1) repeat (v.cycles - 1) @(negedge clk);
        check(v.name);
    endtask

    initial begin
        reset    = 1'b1;
        key_n    = 4'hF;
        flag_clr = 4'h0;
        cnt_clr  = 1'b0;
        @(negedge clk);
        expect_now(32'h0, "reset_first_edge");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        vecs.push_back('{4'hF, 4'h0, 1'b0, 1, 32'h0000_0000, "idle"});
        vecs.push_back('{4'hE, 4'h0, 1'b0, 5, 32'h0000_0000, "press0_edge5"});
        vecs.push_back('{4'hE, 4'h0, 1'b0, 1, 32'h0000_0111, "press0_edge6"});
        vecs.push_back('{4'hF, 4'h0, 1'b0, 5, 32'h0000_0111, "release0_edge5"});
        vecs.push_back('{4'hF, 4'h0, 1'b0, 1, 32'h0000_0110, "release0_edge6"});
        vecs.push_back('{4'hF, 4'h1, 1'b0, 1, 32'h0000_0100, "flag0_clear"});
        vecs.push_back('{4'hB, 4'h0, 1'b0, 3, 32'h0000_0100, "glitch2_low"});
        vecs.push_back('{4'hF, 4'h0, 1'b0, 8, 32'h0000_0100, "glitch2_after"});
        vecs.push_back('{4'h0, 4'h0, 1'b0, 5, 32'h0000_0100, "all_edge5"});
        vecs.push_back('{4'h0, 4'h0, 1'b0, 1, 32'h0000_05FF, "all_edge6"});
        vecs.push_back('{4'h0, 4'hF, 1'b0, 1, 32'h0000_050F, "all_flag_clr"});
        vecs.push_back('{4'hF, 4'h0, 1'b0, 6, 32'h0000_0500, "all_release"});
        vecs.push_back('{4'hD, 4'h0, 1'b0, 5, 32'h0000_0500, "press1_edge5"});
        vecs.push_back('{4'hD, 4'h2, 1'b0, 1, 32'h0000_0622, "set_beats_clr"});
        vecs.push_back('{4'hF, 4'h0, 1'b0, 6, 32'h0000_0620, "release1"});
        vecs.push_back('{4'hC, 4'h0, 1'b0, 5, 32'h0000_0620, "press01_edge5"});
        vecs.push_back('{4'hC, 4'h0, 1'b1, 1, 32'h0000_0233, "cnt_clr_with_2"});
        vecs.push_back('{4'hC, 4'h0, 1'b1, 1, 32'h0000_0033, "cnt_clr_alone"});
        vecs.push_back('{4'hF, 4'h0, 1'b0, 6, 32'h0000_0030, "release01"});
        vecs.push_back('{4'hF, 4'h3, 1'b0, 1, 32'h0000_0000, "flags01_clear"});

        foreach (vecs[i]) apply(vecs[i]);

        // Reset at debounce count 2 with button 3 held through deassertion.
        key_n = 4'h7;
        repeat (4) @(negedge clk);
        expect_now(32'h0000_0000, "mid_debounce_before_rst");
        reset = 1'b1;
        @(negedge clk);
        expect_now(32'h0000_0000, "mid_debounce_rst");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        expect_now(32'h0000_0000, "post_rst_edge5");
        @(negedge clk);
        expect_now(32'h0000_0188, "post_rst_edge6");

        // Counter wrap from 0xFFFFFF.
        force dut.cnt_q = 24'hFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        expect_now(32'hFFFF_FF88, "preload_max");
        key_n = 4'h6;
        repeat (6) @(negedge clk);
        expect_now(32'h0000_0099, "counter_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pb_event_capture.md
PB_EVENT_CAPTURE -- requirements
Module: pb_event_capture

Interface
- REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2^20-1.
- REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
- REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-004 SHALL have port key_n_i, input, 4, raw asynchronous push-button pins, active-low (0 = pressed).
- REQ-005 SHALL have port flag_clr_i, input, 4, per-button sticky-flag clear strobe, driven by a PIO output bit.
- REQ-006 SHALL have port cnt_clr_i, input, 1, press-counter clear strobe.
- REQ-007 SHALL have port push_button_o, output, 32, word for the push_button PIO input: [3:0] debounced level, [7:4] sticky press flags, [31:8] press counter.

Function
- REQ-008 SHALL pass each key_n_i bit through a 2-flop synchronizer, then invert it, so that sample 1 = pressed.
- REQ-009 SHALL keep, per button, a stable level and a 20-bit debounce counter.
- REQ-010 Counter rule when the synchronized sample equals the stable level: counter SHALL clear to 0.
- REQ-011 Counter rule when the sample differs and the counter is below DEBOUNCE_CYCLES-1: counter SHALL increment.
- REQ-012 Counter rule when the sample differs and the counter equals DEBOUNCE_CYCLES-1: stable SHALL take the sample and the counter SHALL clear.
- REQ-013 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged and restart the count.
- REQ-014 Latency: push_button_o[n] SHALL change exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples the new raw level, provided the level is held.
- REQ-015 A press event SHALL be a stable 0->1 transition; a release (1->0) SHALL generate no event.
- REQ-016 Sticky flag [4+n] SHALL set on a press event of button n and clear on flag_clr_i[n].
- REQ-017 When a press event and flag_clr_i[n] coincide in the same cycle, the set SHALL win.
- REQ-018 The press counter SHALL add the number of press events in the cycle (0..4).
- REQ-019 The press counter SHALL be 24 bits and wrap modulo 2^24 (0xFFFFFF + 1 = 0x000000).
- REQ-020 When cnt_clr_i coincides with press events, the counter SHALL load the event count of that cycle, not 0.
- REQ-021 Level, flags and counter SHALL update on the same clock edge; all outputs SHALL be registered, with no combinational path from any input to push_button_o.
- REQ-022 Buttons SHALL be fully independent; activity on one SHALL NOT affect another's debounce counter.

Reset
- REQ-023 Synchronizer flops SHALL reset to 1 (released).
- REQ-024 Stable levels, debounce counters, sticky flags and the press counter SHALL reset to 0; push_button_o SHALL read 0x00000000 on the first edge after reset is asserted.
- REQ-025 Reset asserted mid-debounce SHALL discard the partial count and generate no event.
- REQ-026 If a key is held through reset deassertion, it SHALL be accepted as a normal press DEBOUNCE_CYCLES+2 edges later, with flag set and counter incremented.

Verification (DEBOUNCE_CYCLES=4)
- REQ-027 Clean press: key_n_i[0]=0 held -> push_button_o = 0x00000111 exactly 6 edges later; release -> 0x00000110 6 edges after release.
- REQ-028 Glitch: key_n_i[2] low for 3 cycles, then high -> push_button_o remains 0x00000000 throughout.
- REQ-029 Simultaneous: all four keys pressed on the same cycle -> 0x000004FF; flag_clr_i=0xF for 1 cycle -> 0x0000040F.
- REQ-030 Set/clear collision: flag_clr_i[1] asserted on the acceptance edge of button 1 -> flag [5] = 1 after the edge.
- REQ-031 Wrap/clear: counter preloaded to 0xFFFFFF via 16777215 presses (or a force), one more press -> [31:8] = 0x000000; cnt_clr_i with 2 coincident presses -> [31:8] = 0x000002.
- REQ-032 Reset mid-debounce: reset pulsed at debounce count 2 -> output 0x00000000 and no event; key still held -> press accepted 6 edges after reset deasserts.
